// File: rtl/std_mem_d1_arbiter.sv
// rtl/std_mem_d1_arbiter.sv - round-robin go/done arbiter in front of one std_mem_d1 port
//
// Shares a single std_mem_d1 memory port among NUM_REQ requesters that use the
// Calyx go/done group handshake. One access is in flight at a time. Reads return
// registered data, and writes wait for the memory's done.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a WAIT-state watchdog and the
// timeout_err output. When it is undefined, WAIT holds until mem_done arrives.
//
// Ports:
//   clk, reset       clock (rising edge) and asynchronous active-low reset
//   req_go           per-requester go, held high until that requester's done
//   req_addr         packed addresses, requester i at [i*IDX_SIZE +: IDX_SIZE]
//   req_write_data   packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_write_en     per-requester access type (1 = write, 0 = read)
//   req_done         one-cycle done pulse to the granted requester
//   req_read_data    last read result, valid while req_done is nonzero
//   mem_addr0        memory address
//   mem_write_data   memory write data
//   mem_write_en     memory write enable, one cycle per write
//   mem_read_data    memory combinational read data
//   mem_done         memory done, one cycle after write_en
//   busy             high whenever the FSM is not in IDLE
//   grant_idx        currently (or most recently) granted requester
//   timeout_err      (MEM_ARB_TIMEOUT_EN only) pulses with done when WAIT timed out

module std_mem_d1_arbiter #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 16,
  localparam int REQ_IDX = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_go,
  input  logic [NUM_REQ*IDX_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_write_data,
  input  logic [NUM_REQ-1:0]          req_write_en,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [WIDTH-1:0]            req_read_data,
  output logic [IDX_SIZE-1:0]         mem_addr0,
  output logic [WIDTH-1:0]            mem_write_data,
  output logic                        mem_write_en,
  input  logic [WIDTH-1:0]            mem_read_data,
  input  logic                        mem_done,
  output logic                        busy,
  output logic [REQ_IDX-1:0]          grant_idx
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("std_mem_d1_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t             state;
  logic [REQ_IDX-1:0] rr_ptr;
  logic               lat_we;
  logic               pick_valid;
  logic [REQ_IDX-1:0] pick_idx;
  logic [REQ_IDX-1:0] cand;
  logic [NUM_REQ-1:0] grant_onehot;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] wait_cnt;
`endif

  // Round-robin pick: walk the offsets from the far end back towards rr_ptr so
  // that the lowest offset with go set is the last one written and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = REQ_IDX'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_go[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_onehot = NUM_REQ'(1) << grant_idx;

  // mem_addr0 / mem_write_data double as the latched request; lat_we remembers
  // the access type after mem_write_en has dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      grant_idx      <= '0;
      lat_we         <= 1'b0;
      req_done       <= '0;
      req_read_data  <= '0;
      mem_addr0      <= '0;
      mem_write_data <= '0;
      mem_write_en   <= 1'b0;
      busy           <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_idx      <= pick_idx;
            mem_addr0      <= req_addr[int'(pick_idx)*IDX_SIZE +: IDX_SIZE];
            mem_write_data <= req_write_data[int'(pick_idx)*WIDTH +: WIDTH];
            lat_we         <= req_write_en[pick_idx];
            mem_write_en   <= req_write_en[pick_idx];
            busy           <= 1'b1;
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          mem_write_en <= 1'b0;
          if (lat_we) begin
            state <= S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            // Read data is combinational from the memory while the address is
            // presented, so it is captured here and returned with done.
            req_read_data <= mem_read_data;
            req_done      <= grant_onehot;
            state         <= S_ACK;
          end
        end

        S_WAIT: begin
          if (mem_done) begin
            req_done <= grant_onehot;
            state    <= S_ACK;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == TCW'(TIMEOUT - 1)) begin
            // TIMEOUT cycles spent in WAIT: release the requester anyway.
            req_done    <= grant_onehot;
            timeout_err <= 1'b1;
            state       <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_ACK: begin
          req_done <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
          rr_ptr <= (grant_idx == REQ_IDX'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
